gate_exerciser: RTL and testbench
=================================

# gate_exerciser

Sequencing controller for a 2-input standard-cell gate under test, such as the switch-level NOR. It steps the gate's two inputs through all four input combinations in a fixed order. After each vector settles, it samples the gate output through a synchronizer and compares it against a parameterised truth table. It reports mismatch count and pass/fail, and is the on-chip stimulus/check harness for the team's cell characterisation runs.

## Interface

Parameters:
- SETTLE, 4, cycles held per vector before sampling; legal range 2..15
- TRUTH, 4'b0001, expected output per vector index {a,b}; bit i is the expected value for vector i (default = NOR)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  level; sampled only in IDLE, begins a run
- dut_out  input  1  gate output, asynchronous to clk; 2-flop synchronized internally
- a_drv  output  1  gate input A (vector bit 1)
- b_drv  output  1  gate input B (vector bit 0)
- vec_idx  output  2  current vector index
- busy  output  1  high from APPLY through SAMPLE of vector 3
- done  output  1  one-cycle pulse at run end
- pass  output  1  registered; 1 when last run had zero mismatches
- err_cnt  output  3  mismatches in last/current run, 0..4

## Operation

- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE: a_drv=b_drv=0, vec_idx=0. If start=1, go to APPLY, clear err_cnt, clear pass.
- APPLY: 1 cycle. Drive {a_drv,b_drv}=vec_idx and load the settle counter with SETTLE-1. Go to SETTLE.
- SETTLE: count down and hold drives; at 0, go to SAMPLE.
- SAMPLE: 1 cycle. Compare synchronized dut_out against TRUTH[vec_idx]. On mismatch, err_cnt+1.
  - If vec_idx=3, go to DONE.
  - Otherwise vec_idx+1 and go to APPLY.
- DONE: 1 cycle. done=1, pass=(err_cnt==0 including the final sample). Go to IDLE. Drives return to 0.
- err_cnt never exceeds 4, so no wrap.
- start while busy or in DONE is ignored; no queuing.
- SETTLE<2 is illegal (synchronizer latency). The RTL flags it with an elaboration-time $error.

## Timing

- Reset (async assert, sync release): state=IDLE, a_drv=b_drv=0, vec_idx=0, busy=0, done=0, pass=0, err_cnt=0, synchronizer flops=0.
- start high at edge n (IDLE) -> APPLY at n+1. busy=1 and drives valid from n+1.
- Per vector: 1 (APPLY) + SETTLE + 1 (SAMPLE) = SETTLE+2 cycles.
- Run: 4*(SETTLE+2) busy cycles, then done pulse. With SETTLE=4: busy 24 cycles, done at n+25, back in IDLE at n+26.
- Sampled value is the dut_out present 2 edges before the SAMPLE edge. The gate must settle within SETTLE-1 cycles of the drive change.
- err_cnt updates on the edge ending SAMPLE. pass updates on the DONE edge and holds until the next start.
- Reset mid-run aborts immediately. No done pulse; all outputs return to reset values.

## Configuration

- GATE_EXER_LOOP_EN defined: in SAMPLE of vector 3, if start=1, perform the pass/err bookkeeping and pulse done as DONE would. Then go directly to APPLY with vec_idx=0 and err_cnt cleared, so busy stays high continuously. If start=0, go to DONE as normal.
- Undefined: every run ends in DONE then IDLE. Back-to-back runs have a 2-cycle gap (DONE, IDLE).

## Test plan

- Ideal NOR model on dut_out, SETTLE=4, pulse start -> vectors 00,01,10,11 in order, each held 6 cycles; done at start+25; pass=1, err_cnt=0.
- dut_out stuck at 0 -> mismatch on vector 0 only; err_cnt=1, pass=0.
- dut_out stuck at 1 -> mismatches on vectors 1,2,3; err_cnt=3, pass=0. OR gate model (inverted NOR) -> err_cnt=4.
- Assert rst during SETTLE of vector 2 -> next cycle all outputs at reset values, no done. A subsequent start runs a clean full pass with err_cnt=0.
- Toggle start repeatedly while busy -> run length unchanged, single done pulse. With GATE_EXER_LOOP_EN and start held -> done pulses every 4*(SETTLE+2) cycles, busy never drops.

Source files
------------

// File: rtl/gate_exerciser.sv
// gate_exerciser: steps a 2-input gate through vectors 00,01,10,11 and
// checks its output against TRUTH. Optional macro: GATE_EXER_LOOP_EN.
module gate_exerciser #(
    parameter int unsigned SETTLE = 4,
    parameter logic [3:0]  TRUTH  = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_out,
    output logic       a_drv,
    output logic       b_drv,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt
);

    if (SETTLE < 2 || SETTLE > 15) begin : g_bad_settle
        $error("gate_exerciser: SETTLE must be within 2..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] vec, vec_nxt;
    logic [2:0] err, err_nxt;
    logic       pass_q, pass_nxt;
    logic       sync1, sync2;
    logic       miss;
    logic       done_c;

    assign miss = (sync2 != TRUTH[vec]);

    // two-flop synchronizer for the asynchronous gate output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= dut_out;
            sync2 <= sync1;
        end
    end

    // state and bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            vec    <= 2'd0;
            err    <= 3'd0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            vec    <= vec_nxt;
            err    <= err_nxt;
            pass_q <= pass_nxt;
        end
    end

    // sequencing: apply, settle, sample each vector, then report
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vec_nxt   = vec;
        err_nxt   = err;
        pass_nxt  = pass_q;
        done_c    = 1'b0;
        unique case (state)
            S_IDLE: begin
                vec_nxt = 2'd0;
                if (start) begin
                    state_nxt = S_APPLY;
                    err_nxt   = 3'd0;
                    pass_nxt  = 1'b0;
                end
            end
            S_APPLY: begin
                cnt_nxt   = CNT_LOAD;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_SAMPLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (miss) begin
                    err_nxt = err + 3'd1;
                end
                if (vec == 2'd3) begin
                    vec_nxt   = 2'd0;
                    state_nxt = S_DONE;
`ifdef GATE_EXER_LOOP_EN
                    // back-to-back run: report now, restart without a gap
                    if (start) begin
                        done_c    = 1'b1;
                        pass_nxt  = (err_nxt == 3'd0);
                        err_nxt   = 3'd0;
                        state_nxt = S_APPLY;
                    end
`endif
                end else begin
                    vec_nxt   = vec + 2'd1;
                    state_nxt = S_APPLY;
                end
            end
            S_DONE: begin
                done_c    = 1'b1;
                pass_nxt  = (err == 3'd0);
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy    = (state == S_APPLY) || (state == S_SETTLE) ||
                     (state == S_SAMPLE);
    assign a_drv   = busy & vec[1];
    assign b_drv   = busy & vec[0];
    assign vec_idx = vec;
    assign done    = done_c;
    assign pass    = pass_q;
    assign err_cnt = err;

endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: directed vectors for gate_exerciser with a
// behavioural gate model (NOR, stuck-0, stuck-1, OR).
module tb_gate_exerciser;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dut_out;
    logic       a_drv;
    logic       b_drv;
    logic [1:0] vec_idx;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;

    int nvec = 0;
    int nbad = 0;
    int mode = 0;

    always #5 clk = ~clk;

    assign dut_out = (mode == 0) ? ~(a_drv | b_drv) :
                     (mode == 1) ? 1'b0 :
                     (mode == 2) ? 1'b1 :
                                   (a_drv | b_drv);

    gate_exerciser #(.SETTLE(4), .TRUTH(4'b0001)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .dut_out(dut_out),
        .a_drv  (a_drv),
        .b_drv  (b_drv),
        .vec_idx(vec_idx),
        .busy   (busy),
        .done   (done),
        .pass   (pass),
        .err_cnt(err_cnt)
    );

    typedef struct {
        int         mode;
        bit         tog;
        logic [2:0] err;
        logic       pass;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " a_drv"}, 32'(a_drv), 32'd0);
        chk({tag, " b_drv"}, 32'(b_drv), 32'd0);
        chk({tag, " vec_idx"}, 32'(vec_idx), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " pass"}, 32'(pass), 32'd0);
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // one full run: 24 busy cycles (6 per vector), then DONE, then IDLE
    task automatic run_one(input bit tog);
        logic [1:0] ev;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 24; k++) begin
            ev = 2'(k / 6);
            chk("busy", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            chk("vec_idx", 32'(vec_idx), 32'(ev));
            chk("drives", 32'({a_drv, b_drv}), 32'(ev));
            if (tog) start = k[0];
            tick();
        end
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("drv_done", 32'({a_drv, b_drv}), 32'd0);
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        tbl[0] = '{mode: 0, tog: 1'b0, err: 3'd0, pass: 1'b1};
        tbl[1] = '{mode: 1, tog: 1'b0, err: 3'd1, pass: 1'b0};
        tbl[2] = '{mode: 2, tog: 1'b0, err: 3'd3, pass: 1'b0};
        tbl[3] = '{mode: 3, tog: 1'b0, err: 3'd4, pass: 1'b0};
        tbl[4] = '{mode: 0, tog: 1'b1, err: 3'd0, pass: 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        tick();
        tick();
        chk_reset_outs("reset");
        rst = 1'b0;
        tick();
        chk_reset_outs("idle");

        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            run_one(tbl[i].tog);
            chk($sformatf("err_cnt[%0d]", i), 32'(err_cnt), 32'(tbl[i].err));
            chk($sformatf("pass[%0d]", i), 32'(pass), 32'(tbl[i].pass));
        end

        // abort during SETTLE of vector 2 with an OR gate (err_cnt=2 by then)
        mode  = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        chk("abort_vec", 32'(vec_idx), 32'd2);
        chk("abort_err", 32'(err_cnt), 32'd2);
        rst = 1'b1;
        #1;
        chk_reset_outs("async_rst");
        tick();
        chk_reset_outs("rst_hold");
        rst = 1'b0;
        tick();
        chk_reset_outs("post_rst");
        mode = 0;
        run_one(1'b0);
        chk("clean_err", 32'(err_cnt), 32'd0);
        chk("clean_pass", 32'(pass), 32'd1);

`ifdef GATE_EXER_LOOP_EN
        // start held: done every 24 cycles, busy never drops
        mode  = 0;
        start = 1'b1;
        tick();
        for (int c = 0; c < 48; c++) begin
            chk("loop_busy", 32'(busy), 32'd1);
            chk("loop_done", 32'(done), (c % 24 == 23) ? 32'd1 : 32'd0);
            tick();
        end
        start = 1'b0;
        repeat (25) tick();
        chk("loop_end_busy", 32'(busy), 32'd0);
        chk("loop_pass", 32'(pass), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
